// File: rtl/fpu_pkg.sv
// Shared FPU definitions: field layout of the 32-bit custom float, exponent
// constants and the one-hot status encoding common to the converter and adder.
package fpu_pkg;

    localparam int EXP_BIAS = 31;
    localparam int EXP_W    = 6;
    localparam int MANT_W   = 25;
    localparam int EXP_MAX  = 63;

    localparam int SIGN_POS = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 25;
    localparam int MANT_MSB = 24;
    localparam int MANT_LSB = 0;

    // Biased exponent of a 32-bit integer whose top bit is set; no integer can exceed it
    localparam logic [EXP_W-1:0] INT_EXP_TOP = 6'(EXP_BIAS + 31);

    typedef enum logic [3:0] {
        ST_EXACT     = 4'b0001,
        ST_INEXACT   = 4'b0010,
        ST_OVERFLOW  = 4'b0100,
        ST_UNDERFLOW = 4'b1000
    } status_out_t;

    function automatic logic [31:0] fp_pack(
        input logic              sign,
        input logic [EXP_W-1:0]  exp,
        input logic [MANT_W-1:0] mant
    );
        fp_pack = {sign, exp, mant};
    endfunction

endpackage

// File: rtl/int_to_fp_if.sv
// Request/result bundle of the integer-to-float converter.
interface int_to_fp_if;
    import fpu_pkg::*;

    logic        start;
    logic [31:0] int_in;
    logic [31:0] data_out;
    logic [3:0]  status_out;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output int_in,
        input  data_out,
        input  status_out,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  int_in,
        output data_out,
        output status_out,
        output busy,
        output done
    );

endinterface

// File: rtl/fp_round_pack.sv
// Rounds a normalized 32-bit magnitude to the 25-bit mantissa (nearest, ties
// away from zero) and packs it with sign and exponent.
module fp_round_pack
    import fpu_pkg::*;
(
    input  logic             sign,
    input  logic [EXP_W-1:0] exp,
    input  logic [31:0]      mag,
    output logic [31:0]      word,
    output logic             inexact
);

    logic [MANT_W-1:0] mant_s;
    logic [EXP_W-1:0]  exp_s;
    logic              guard_s;
    logic              sticky_s;

    // Round the mantissa, carrying into the exponent on all-ones overflow
    always_comb begin
        mant_s   = mag[30:6];
        exp_s    = exp;
        guard_s  = mag[5];
        sticky_s = |mag[4:0];
        if (guard_s) begin
            if (&mag[30:6]) begin
                mant_s = {MANT_W{1'b0}};
                if (exp < INT_EXP_TOP) begin
                    exp_s = exp + 6'd1;
                end else begin
                    exp_s = exp;
                end
            end else begin
                mant_s = mag[30:6] + 25'd1;
                exp_s  = exp;
            end
        end else begin
            mant_s = mag[30:6];
            exp_s  = exp;
        end
    end

    // Without the hidden bit the magnitude is zero, which encodes as all zeros
    always_comb begin
        word    = 32'd0;
        inexact = 1'b0;
        if (mag[31]) begin
            word    = fp_pack(sign, exp_s, mant_s);
            inexact = guard_s | sticky_s;
        end else begin
            word    = 32'd0;
            inexact = 1'b0;
        end
    end

endmodule

// File: rtl/int_to_fp.sv
// Iterative signed-integer to custom-float converter: one normalization shift
// per cycle, then round and present the result with a one-cycle done pulse.
module int_to_fp
    import fpu_pkg::*;
(
    input  logic       clock100KHz,
    input  logic       reset,
    int_to_fp_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ABS   = 3'd1,
        S_NORM  = 3'd2,
        S_ROUND = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t           state_r;
    logic [31:0]      int_r;
    logic             sign_r;
    logic [31:0]      mag_r;
    logic [EXP_W-1:0] exp_r;
    logic [31:0]      packed_r;
    logic             inexact_r;
    logic [31:0]      data_out_r;
    status_out_t      status_r;
    logic             busy_r;
    logic             done_r;

    logic [31:0]      abs_s;
    logic [31:0]      rp_word_s;
    logic             rp_inexact_s;

    // Two's-complement magnitude; -2^31 wraps to 0x80000000, which is its true magnitude
    always_comb begin
        abs_s = int_r;
        if (int_r[31]) begin
            abs_s = ~int_r + 32'd1;
        end else begin
            abs_s = int_r;
        end
    end

    fp_round_pack u_round_pack (
        .sign    (sign_r),
        .exp     (exp_r),
        .mag     (mag_r),
        .word    (rp_word_s),
        .inexact (rp_inexact_s)
    );

    // Conversion FSM with registered results and handshake outputs
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            int_r      <= 32'd0;
            sign_r     <= 1'b0;
            mag_r      <= 32'd0;
            exp_r      <= 6'd0;
            packed_r   <= 32'd0;
            inexact_r  <= 1'b0;
            data_out_r <= 32'd0;
            status_r   <= ST_EXACT;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        int_r   <= bus.int_in;
                        busy_r  <= 1'b1;
                        state_r <= S_ABS;
                    end
                end
                S_ABS: begin
                    sign_r <= int_r[31];
                    mag_r  <= abs_s;
                    exp_r  <= INT_EXP_TOP;
                    if (abs_s == 32'd0) begin
                        packed_r  <= 32'd0;
                        inexact_r <= 1'b0;
                        state_r   <= S_OUT;
                    end else begin
                        state_r <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (mag_r[31]) begin
                        state_r <= S_ROUND;
                    end else begin
                        mag_r <= {mag_r[30:0], 1'b0};
                        exp_r <= exp_r - 6'd1;
                    end
                end
                S_ROUND: begin
                    packed_r  <= rp_word_s;
                    inexact_r <= rp_inexact_s;
                    state_r   <= S_OUT;
                end
                S_OUT: begin
                    data_out_r <= packed_r;
                    status_r   <= inexact_r ? ST_INEXACT : ST_EXACT;
                    done_r     <= 1'b1;
                    busy_r     <= 1'b0;
                    state_r    <= S_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.data_out   = data_out_r;
    assign bus.status_out = status_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;

endmodule

// File: tb/tb_int_to_fp.sv
// Directed bench for int_to_fp: reset values, hand-computed conversions with
// latency, ignored start requests and a mid-conversion reset.
module tb_int_to_fp;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    int_to_fp_if bus ();

    int_to_fp dut (
        .clock100KHz (clk),
        .reset       (rst),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_data"},   bus.data_out, 32'h0000_0000);
        check({tag, "_status"}, {28'd0, bus.status_out}, 32'd1);
        check({tag, "_busy"},   {31'd0, bus.busy}, 32'd0);
        check({tag, "_done"},   {31'd0, bus.done}, 32'd0);
    endtask

    // Called in the slot just after a rising edge; returns in the done cycle,
    // or 45 cycles later when a stray start was injected at edge poke_edge.
    task automatic convert(input string tag, input logic [31:0] val,
                           input logic [31:0] want_word, input logic [3:0] want_st,
                           input int want_edge, input int poke_edge);
        int edge_n;
        int extra_dones;
        bus.start  = 1'b1;
        bus.int_in = val;
        @(posedge clk); #1;
        edge_n     = 1;
        bus.start  = 1'b0;
        bus.int_in = 32'h5A5A_A5A5;
        check({tag, "_busy_rise"}, {31'd0, bus.busy}, 32'd1);
        check({tag, "_done_low"},  {31'd0, bus.done}, 32'd0);
        while (!bus.done && edge_n < 60) begin
            if (edge_n == poke_edge) begin
                bus.start  = 1'b1;
                bus.int_in = 32'd5;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            edge_n++;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, edge_n, want_edge);
        check({tag, "_data"},    bus.data_out, want_word);
        check({tag, "_status"},  {28'd0, bus.status_out}, {28'd0, want_st});
        check({tag, "_busy_fall"}, {31'd0, bus.busy}, 32'd0);
        if (poke_edge > 0) begin
            extra_dones = 0;
            repeat (45) begin
                @(posedge clk); #1;
                if (bus.done) extra_dones++;
            end
            check({tag, "_no_second_done"}, extra_dones, 32'd0);
            check({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
            check({tag, "_data_held"}, bus.data_out, want_word);
        end
    endtask

    initial begin
        int dones;
        checks     = 0;
        failures   = 0;
        rst        = 1'b0;
        bus.start  = 1'b0;
        bus.int_in = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // Back-to-back: each start lands on the edge that ends the previous done cycle
        convert("one",      32'h0000_0001, 32'h3E00_0000, 4'b0001, 36, 0);
        convert("minus6",   32'hFFFF_FFFA, 32'hC300_0000, 4'b0001, 34, 0);
        convert("zero",     32'h0000_0000, 32'h0000_0000, 4'b0001, 3,  0);
        convert("minmin",   32'h8000_0000, 32'hFC00_0000, 4'b0001, 5,  0);
        convert("maxpos",   32'h7FFF_FFFF, 32'h7C00_0000, 4'b0010, 6,  0);
        convert("tie_away", 32'h0400_0001, 32'h7200_0001, 4'b0010, 10, 0);

        // Reset pulled during NORM aborts the conversion
        bus.start  = 1'b1;
        bus.int_in = 32'h0000_0010;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset_vals("abort");
        dones = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check("abort_no_done", dones, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        convert("after_abort", 32'hFFFF_FFFA, 32'hC300_0000, 4'b0001, 34, 0);

        // Stray start during NORM, then during the OUT cycle
        @(posedge clk); #1;
        convert("poke_norm", 32'h0000_0100, 32'h4E00_0000, 4'b0001, 28, 5);
        convert("poke_out",  32'h0000_0100, 32'h4E00_0000, 4'b0001, 28, 27);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
